// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding and
// the oversampling ratios the receiver supports.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned PrescaleX8  = 8;
    localparam int unsigned PrescaleX16 = 16;
    localparam int unsigned PrescaleX32 = 32;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX pin/datapath and the UART receive frame sequencer.
interface uart_rx_ctrl_if #(
    parameter int unsigned PW = 6
);
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          samp_en;
    logic [PW-1:0] edge_cnt;
    logic          deser_en;
    logic          deser_done;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          flags_done;
    logic          data_valid;

    modport master (
        output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  samp_en, edge_cnt, deser_en, deser_done, strt_chk_en, par_chk_en,
               stp_chk_en, flags_done, data_valid
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output samp_en, edge_cnt, deser_en, deser_done, strt_chk_en, par_chk_en,
               stp_chk_en, flags_done, data_valid
    );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampled-edge counter and data-bit counter for the UART receive sequencer.
module uart_rx_edge_bit_counter #(
    parameter int unsigned Prescale_Width = 6,
    parameter int unsigned Bit_Width      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      restart_i,
    input  logic                      wrap_i,
    input  logic                      en_i,
    input  logic                      bit_clr_i,
    input  logic                      bit_inc_i,
    output logic [Prescale_Width-1:0] edge_cnt_o,
    output logic [Bit_Width-1:0]      bit_cnt_o
);
    logic [Prescale_Width-1:0] edge_cnt_q, edge_cnt_d;
    logic [Bit_Width-1:0]      bit_cnt_q, bit_cnt_d;

    // The cycle that detects a start edge is edge 0, so a new frame resumes at 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (clr_i) begin
            edge_cnt_d = '0;
        end else if (restart_i) begin
            edge_cnt_d = Prescale_Width'(1);
        end else if (wrap_i) begin
            edge_cnt_d = '0;
        end else if (en_i) begin
            edge_cnt_d = edge_cnt_q + Prescale_Width'(1);
        end

        bit_cnt_d = bit_cnt_q;
        if (bit_clr_i) begin
            bit_cnt_d = '0;
        end else if (bit_inc_i) begin
            bit_cnt_d = bit_cnt_q + Bit_Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: detects the start edge, tracks edge/bit position
// and pulses the sampler, checker and deserializer enables.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned Data_Width     = 8,
    parameter int unsigned Prescale_Width = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned BW = $clog2(Data_Width + 1);
    typedef logic [Prescale_Width-1:0] edge_t;

    rx_state_e state_q, state_d;
    edge_t     p_q, p_d;
    logic      par_en_q, par_en_d;
    logic      par_err_l_q, par_err_l_d;
    logic      stp_err_l_q, stp_err_l_d;

    edge_t          edge_cnt, sp, p_last;
    logic [BW-1:0]  bit_cnt;
    logic           at_sp, at_sp1, at_last, last_bit, stp_err_now, frame_start;
    logic           cnt_clr, cnt_restart, cnt_wrap, cnt_en, bit_clr, bit_inc;
    logic           samp_en, deser_en, deser_done, strt_chk_en, par_chk_en, stp_chk_en;
    logic           flags_done, data_valid;

    assign sp       = (p_q >> 1) + edge_t'(2);
    assign p_last   = p_q - edge_t'(1);
    assign at_sp    = (edge_cnt == sp);
    assign at_sp1   = (edge_cnt == sp + edge_t'(1));
    assign at_last  = (edge_cnt == p_last);
    assign last_bit = (bit_cnt == BW'(Data_Width - 1));
    // With P=8 the stop result arrives on the final edge, so bypass the latch.
    assign stp_err_now = stp_err_l_q | (at_sp1 & bus.stp_err);

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        par_en_d    = par_en_q;
        par_err_l_d = par_err_l_q;
        stp_err_l_d = stp_err_l_q;
        frame_start = 1'b0;
        cnt_clr     = 1'b0;
        cnt_restart = 1'b0;
        cnt_wrap    = 1'b0;
        cnt_en      = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        samp_en     = 1'b0;
        deser_en    = 1'b0;
        deser_done  = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        flags_done  = 1'b0;
        data_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_clr = 1'b1;
                if (!bus.RX_IN) begin
                    state_d     = StStart;
                    frame_start = 1'b1;
                    cnt_restart = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            StStart: begin
                samp_en     = 1'b1;
                cnt_en      = 1'b1;
                strt_chk_en = at_sp;
                if (at_sp1 && bus.strt_glitch) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end else if (at_last) begin
                    state_d  = StData;
                    cnt_wrap = 1'b1;
                end
            end
            StData: begin
                samp_en    = 1'b1;
                cnt_en     = 1'b1;
                deser_en   = at_sp;
                deser_done = at_sp1 && last_bit;
                if (at_last) begin
                    cnt_wrap = 1'b1;
                    if (last_bit) begin
                        bit_clr = 1'b1;
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            StParity: begin
                samp_en    = 1'b1;
                cnt_en     = 1'b1;
                par_chk_en = at_sp;
                if (at_sp1) par_err_l_d = bus.par_err;
                if (at_last) begin
                    cnt_wrap = 1'b1;
                    state_d  = StStop;
                end
            end
            StStop: begin
                samp_en    = 1'b1;
                cnt_en     = 1'b1;
                stp_chk_en = at_sp;
                if (at_sp1) stp_err_l_d = bus.stp_err;
                if (at_last) begin
                    flags_done  = 1'b1;
                    data_valid  = ~par_err_l_q & ~stp_err_now;
                    par_err_l_d = 1'b0;
                    stp_err_l_d = 1'b0;
                    if (!bus.RX_IN) begin
                        state_d     = StStart;
                        frame_start = 1'b1;
                        cnt_restart = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_clr = 1'b1;
            end
        endcase

        if (frame_start) begin
            p_d      = bus.Prescale;
            par_en_d = bus.PAR_EN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            p_q         <= '0;
            par_en_q    <= 1'b0;
            par_err_l_q <= 1'b0;
            stp_err_l_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            par_en_q    <= par_en_d;
            par_err_l_q <= par_err_l_d;
            stp_err_l_q <= stp_err_l_d;
        end
    end

    uart_rx_edge_bit_counter #(
        .Prescale_Width(Prescale_Width),
        .Bit_Width     (BW)
    ) u_counter (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (cnt_clr),
        .restart_i (cnt_restart),
        .wrap_i    (cnt_wrap),
        .en_i      (cnt_en),
        .bit_clr_i (bit_clr),
        .bit_inc_i (bit_inc),
        .edge_cnt_o(edge_cnt),
        .bit_cnt_o (bit_cnt)
    );

    assign bus.samp_en     = samp_en;
    assign bus.edge_cnt    = edge_cnt;
    assign bus.deser_en    = deser_en;
    assign bus.deser_done  = deser_done;
    assign bus.strt_chk_en = strt_chk_en;
    assign bus.par_chk_en  = par_chk_en;
    assign bus.stp_chk_en  = stp_chk_en;
    assign bus.flags_done  = flags_done;
    assign bus.data_valid  = data_valid;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, stubs the checkers, and compares
// pulse timing against a frame-schedule model built from bit positions.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int unsigned PW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    uart_rx_ctrl_if #(.PW(PW)) bus ();

    uart_rx_ctrl #(
        .Data_Width    (8),
        .Prescale_Width(PW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Checker stubs: results appear one cycle after each enable.
    logic par_acc;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.strt_glitch <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
            par_acc         <= 1'b0;
        end else begin
            bus.strt_glitch <= bus.strt_chk_en & bus.RX_IN;
            bus.stp_err     <= bus.stp_chk_en & ~bus.RX_IN;
            bus.par_err     <= bus.par_chk_en & (bus.RX_IN != par_acc);
            if (bus.strt_chk_en) par_acc <= 1'b0;
            else if (bus.deser_en) par_acc <= par_acc ^ bus.RX_IN;
        end
    end

    int q_strt[$], q_deser[$], q_done[$], q_par[$], q_stp[$], q_flags[$], q_valid[$];
    int e_strt[$], e_deser[$], e_done[$], e_par[$], e_stp[$], e_flags[$], e_valid[$];
    int samp_cnt, edge_sum, multi_cnt, exp_samp, exp_edge_sum;

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.strt_chk_en) q_strt.push_back(cyc);
            if (bus.deser_en)    q_deser.push_back(cyc);
            if (bus.deser_done)  q_done.push_back(cyc);
            if (bus.par_chk_en)  q_par.push_back(cyc);
            if (bus.stp_chk_en)  q_stp.push_back(cyc);
            if (bus.flags_done)  q_flags.push_back(cyc);
            if (bus.data_valid)  q_valid.push_back(cyc);
            if (bus.samp_en) samp_cnt++;
            edge_sum += int'(bus.edge_cnt);
            if (int'(bus.deser_en) + int'(bus.strt_chk_en) + int'(bus.par_chk_en)
                + int'(bus.stp_chk_en) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input int got[$], input int exp[$]);
        check({tag, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic clear_all();
        q_strt.delete(); q_deser.delete(); q_done.delete(); q_par.delete();
        q_stp.delete(); q_flags.delete(); q_valid.delete();
        e_strt.delete(); e_deser.delete(); e_done.delete(); e_par.delete();
        e_stp.delete(); e_flags.delete(); e_valid.delete();
        samp_cnt = 0; edge_sum = 0; multi_cnt = 0; exp_samp = 0; exp_edge_sum = 0;
    endtask

    task automatic check_all(input string tag);
        check_q({tag, " strt_chk_en"}, q_strt, e_strt);
        check_q({tag, " deser_en"}, q_deser, e_deser);
        check_q({tag, " deser_done"}, q_done, e_done);
        check_q({tag, " par_chk_en"}, q_par, e_par);
        check_q({tag, " stp_chk_en"}, q_stp, e_stp);
        check_q({tag, " flags_done"}, q_flags, e_flags);
        check_q({tag, " data_valid"}, q_valid, e_valid);
        check({tag, " samp_cycles"}, samp_cnt, exp_samp);
        check({tag, " edge_sum"}, edge_sum, exp_edge_sum);
        check({tag, " enable_overlap"}, multi_cnt, 0);
        clear_all();
    endtask

    // Reference: bit k of a frame occupies cycles t0+k*p .. t0+k*p+p-1.
    task automatic model_frame(input int t0, input int p, input bit pe, input bit glitch,
                               input bit par_bad, input bit stop_bad);
        int sp, nb;
        sp = p / 2 + 2;
        nb = 10 + int'(pe);
        e_strt.push_back(t0 + sp);
        if (glitch) begin
            exp_samp     += sp + 1;
            exp_edge_sum += (sp + 1) * (sp + 2) / 2;
            return;
        end
        for (int i = 0; i < 8; i++) e_deser.push_back(t0 + (1 + i) * p + sp);
        e_done.push_back(t0 + 8 * p + sp + 1);
        if (pe) e_par.push_back(t0 + 9 * p + sp);
        e_stp.push_back(t0 + (nb - 1) * p + sp);
        e_flags.push_back(t0 + nb * p - 1);
        if (!par_bad && !stop_bad) e_valid.push_back(t0 + nb * p - 1);
        exp_samp     += nb * p - 1;
        exp_edge_sum += nb * p * (p - 1) / 2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            bus.RX_IN = 1'b1;
        end
    endtask

    // Drives ncyc cycles of a frame (0 = whole frame); optionally disturbs the
    // configuration inputs mid-frame.
    task automatic drive_frame(input int p, input bit pe, input logic [7:0] data,
                               input bit par_bad, input bit stop_bit, input int ncyc,
                               input bit scramble, output int t0);
        logic [10:0] bits;
        int nb, len;
        nb = 10 + int'(pe);
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (pe) bits[9] = (^data) ^ par_bad;
        bits[nb-1] = stop_bit;
        len = (ncyc == 0) ? nb * p : ncyc;
        @(posedge CLK); #1;
        t0 = cyc;
        bus.Prescale = PW'(p);
        bus.PAR_EN   = pe;
        for (int j = 0; j < len; j++) begin
            if (j > 0) begin
                @(posedge CLK); #1;
            end
            bus.RX_IN = bits[j/p];
            if (scramble && j == p) begin
                bus.Prescale = (p == PrescaleX8) ? PW'(PrescaleX32) : PW'(PrescaleX8);
                bus.PAR_EN   = ~pe;
            end
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.samp_en, bus.edge_cnt, bus.deser_en, bus.deser_done, bus.strt_chk_en,
                    bus.par_chk_en, bus.stp_chk_en, bus.flags_done, bus.data_valid});
    endfunction

    initial begin
        int t0, t1, p, pe, pb;
        logic [7:0] d;
        bus.RX_IN = 1'b1;
        bus.Prescale = PW'(PrescaleX8);
        bus.PAR_EN = 1'b0;
        clear_all();

        #2 RST = 1'b1;
        #1 check("reset outputs", out_vec(), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(3);
        check("idle outputs", out_vec(), 0);
        clear_all();

        drive_frame(PrescaleX8, 1'b1, 8'hA5, 1'b0, 1'b1, 0, 1'b0, t0);
        model_frame(t0, PrescaleX8, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("p8_par_a5");

        drive_frame(PrescaleX16, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 1'b0, t0);
        model_frame(t0, PrescaleX16, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("p16_nopar_3c");

        drive_frame(PrescaleX8, 1'b0, 8'hFF, 1'b0, 1'b1, 3, 1'b0, t0);
        model_frame(t0, PrescaleX8, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(12);
        check_all("glitch");

        drive_frame(PrescaleX8, 1'b1, 8'h96, 1'b1, 1'b1, 0, 1'b0, t0);
        model_frame(t0, PrescaleX8, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all("par_err");

        d = 8'($urandom);
        drive_frame(PrescaleX8, 1'b0, 8'h5A, 1'b0, 1'b0, 10 * PrescaleX8 - 1, 1'b0, t0);
        drive_frame(PrescaleX8, 1'b1, d, 1'b0, 1'b1, 0, 1'b0, t1);
        model_frame(t0, PrescaleX8, 1'b0, 1'b0, 1'b0, 1'b1);
        model_frame(t1, PrescaleX8, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("stop_err_b2b");

        drive_frame(PrescaleX8, 1'b1, 8'hC3, 1'b0, 1'b1, 4 * PrescaleX8 + 3, 1'b0, t0);
        @(posedge CLK); #1;
        check("pre-reset samp_en", 32'(bus.samp_en), 1);
        RST = 1'b1;
        bus.RX_IN = 1'b1;
        #1 check("mid-frame reset outputs", out_vec(), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(2);
        clear_all();
        d = 8'($urandom);
        drive_frame(PrescaleX32, 1'b1, d, 1'b0, 1'b1, 0, 1'b0, t0);
        model_frame(t0, PrescaleX32, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("after_reset");

        for (int n = 0; n < 6; n++) begin
            case ($urandom_range(0, 2))
                0:       p = PrescaleX8;
                1:       p = PrescaleX16;
                default: p = PrescaleX32;
            endcase
            pe = int'($urandom_range(0, 1));
            pb = (pe == 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
            d  = 8'($urandom);
            drive_frame(p, pe[0], d, pb[0], 1'b1, 0, 1'b1, t0);
            model_frame(t0, p, pe[0], 1'b0, pb[0], 1'b0);
            idle(3);
            check_all($sformatf("rand%0d_p%0d_pe%0d", n, p, pe));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
